rs_gf8_locator_sched: RTL and testbench
=======================================

# rs_gf8_locator_sched

Time-multiplexed single-symbol error locator for the lpGBT emulator's RS(7,5) over GF(2^3) decoder. It arbitrates round-robin between NUM_CH syndrome producers and sequences one shared GF(8) log table through two lookups per request. It returns error position (log S1 − log S0 mod 7), error magnitude (S0) and status flags. It sits between the per-channel syndrome calculators and the symbol correctors.

## Interface
- NUM_CH, 4, number of requesting syndrome channels (2..8)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_CH  per-channel request; held with data until accepted
- req_ready  out  NUM_CH  one-hot grant/accept, combinational
- req_s0  in  3*NUM_CH  syndrome S0 per channel, channel c at [3c+2:3c]
- req_s1  in  3*NUM_CH  syndrome S1 per channel, same packing
- rsp_valid  out  1  one-cycle result strobe, registered
- rsp_ch  out  $clog2(NUM_CH)  channel the result belongs to
- rsp_pos  out  3  error symbol position 0..6
- rsp_mag  out  3  error magnitude (XOR into symbol at rsp_pos)
- rsp_noerr  out  1  S0 = S1 = 0, codeword clean
- rsp_fail  out  1  exactly one syndrome zero, uncorrectable

## Operation
- FSM states: IDLE, LOG0, LOG1, DONE.
- IDLE: if any req_valid, grant the first asserted channel after last_grant, searching circularly. Drive req_ready for that channel only. On the same edge, latch S0/S1/channel, update last_grant and go to LOG0. Otherwise stay in IDLE with req_ready = 0.
- LOG0: log table input = latched S0; register l0 and z0 (log err flag). Next state is LOG1.
- LOG1: log table input = latched S1; register l1 and z1. Next state is DONE.
- DONE: rsp_valid = 1 with registered results. Next state is IDLE.
- Only one log table instance exists. Its input mux is selected by state; in IDLE and DONE the input is 0.
- Result rules:
  - z0 & z1 → noerr = 1, fail = 0, pos = 0, mag = 0.
  - z0 ^ z1 → fail = 1, noerr = 0, pos = 0, mag = 0.
  - Neither zero → pos = l1 − l0 if l1 ≥ l0, else l1 + 7 − l0. Use a 4-bit intermediate; the result is always 0..6. mag = S0.
- Response path has no backpressure; consumers must accept rsp_valid in its cycle.
- Requester rule: req_valid and data stay stable until req_ready. Deasserting before grant is legal and has no effect.
- Reset values: state IDLE, last_grant = NUM_CH−1 (channel 0 has first priority), all latches 0. Outputs: rsp_valid 0, rsp_ch 0, rsp_pos 0, rsp_mag 0, rsp_noerr 0, rsp_fail 0. req_ready is 0 during reset.
- Reset mid-operation: the transaction in flight is discarded with no rsp_valid. The requester's valid is still high, so it is re-arbitrated after reset release.

## Timing
- Acceptance edge A (req_ready & req_valid in cycle A): LOG0 in A+1, LOG1 in A+2, rsp_valid in A+3.
- Fixed latency of 3 cycles after acceptance; no early exit for zero syndromes.
- Next grant is possible at the earliest in cycle A+4. Sustained throughput is one request per 4 cycles.
- Simultaneous requests: exactly one grant per IDLE cycle; round-robin guarantees each channel is served within NUM_CH grants.
- New requests arriving during LOG0/LOG1/DONE wait; req_ready stays 0 outside IDLE.
- Response outputs hold their values after DONE until the next DONE. Only rsp_valid pulses.

## Structure
- Shared package lpgbt_fec_pkg holds GF_W = 3, RS_N = 7 and the FSM state enum, for reuse by sibling FEC blocks.
- One shared GF(8) log table instance: the existing gf_log_3 (op → res, err).
- Natural sub-module: rs_rr_arb, an NUM_CH-wide round-robin arbiter with a last_grant register and an advance input.
- The modulo-7 subtraction stays inline.

## Test plan
- Ch0 only, S0 = 1, S1 = 3 → rsp_valid at A+3, rsp_ch 0, pos 3, mag 1, noerr 0, fail 0.
- Ch2, S0 = 5, S1 = 2 (l0 = 6, l1 = 1, wrap case) → pos 2, mag 5.
- Ch1, S0 = 0, S1 = 0 → noerr 1, pos 0, mag 0. Then S0 = 4, S1 = 0 → fail 1, pos 0, mag 0.
- All 4 channels requesting continuously from reset → grant order 0, 1, 2, 3, 0…, rsp_valid every 4th cycle, rsp_ch matches.
- Assert rst_n low in the LOG1 cycle → no rsp_valid. All outputs are at reset values within the reset. After release, the same channel is regranted and its result appears 3 cycles after acceptance.
- Exhaustive sweep of all 64 S0/S1 pairs on one channel against a reference model of log/mod-7 → all fields match.

Source files
------------

// File: rtl/lpgbt_fec_pkg.sv
// Shared constants and types for the lpGBT RS(7,5) GF(2^3) FEC blocks.
package lpgbt_fec_pkg;

  localparam int GF_W = 3;   // symbol width
  localparam int RS_N = 7;   // multiplicative group order of GF(8)

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOG0 = 2'd1,
    LOG1 = 2'd2,
    DONE = 2'd3
  } fec_state_e;

  // Registered locator result carried to the symbol correctors
  typedef struct packed {
    logic [GF_W-1:0] pos;
    logic [GF_W-1:0] mag;
    logic            noerr;
    logic            fail;
  } loc_rsp_t;

endpackage

// File: rtl/gf_log_3.sv
// GF(8) discrete log, primitive polynomial x^3 + x + 1, alpha = 3'b010.
// err flags op == 0, whose log is undefined; res is 0 in that case.
module gf_log_3
  import lpgbt_fec_pkg::*;
(
  input  logic [GF_W-1:0] op,
  output logic [GF_W-1:0] res,
  output logic            err
);

  // Lookup table: alpha^k for k = 0..6 is 1,2,4,3,6,7,5
  always_comb begin
    res = '0;
    err = 1'b0;
    case (op)
      3'd1: res = 3'd0;
      3'd2: res = 3'd1;
      3'd3: res = 3'd3;
      3'd4: res = 3'd2;
      3'd5: res = 3'd6;
      3'd6: res = 3'd4;
      3'd7: res = 3'd5;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/rs_rr_arb.sv
// NUM_CH-wide round-robin arbiter. Grant is combinational; the search starts
// one past last_grant and wraps. advance commits the current grant.
module rs_rr_arb #(
  parameter  int NUM_CH = 4,
  localparam int CW     = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] gnt,
  output logic [CW-1:0]     gnt_idx
);

  logic [CW-1:0] last_grant;
  logic [CW-1:0] idx;
  logic          found;
  int            c;

  // Circular priority search starting after last_grant
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    c       = 0;
    idx     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      c = int'(last_grant) + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      idx = CW'(c);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

  // Remember the winner; reset value gives channel 0 first priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                last_grant <= CW'(NUM_CH - 1);
    else if (advance && found) last_grant <= gnt_idx;
  end

endmodule

// File: rtl/rs_gf8_locator_sched.sv
// Time-multiplexed single-symbol error locator for RS(7,5) over GF(8).
// Round-robin over NUM_CH syndrome producers, one shared log table used
// twice per request (S0 then S1), fixed 3-cycle latency after acceptance.
module rs_gf8_locator_sched
  import lpgbt_fec_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CW     = $clog2(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH-1:0]      req_valid,
  output logic [NUM_CH-1:0]      req_ready,
  input  logic [GF_W*NUM_CH-1:0] req_s0,
  input  logic [GF_W*NUM_CH-1:0] req_s1,
  output logic                   rsp_valid,
  output logic [CW-1:0]          rsp_ch,
  output logic [GF_W-1:0]        rsp_pos,
  output logic [GF_W-1:0]        rsp_mag,
  output logic                   rsp_noerr,
  output logic                   rsp_fail
);

  fec_state_e                   state;
  logic [NUM_CH-1:0][GF_W-1:0]  s0_v, s1_v;
  logic [NUM_CH-1:0]            gnt;
  logic [CW-1:0]                gnt_idx;
  logic                         accept;
  logic [GF_W-1:0]              s0_q, s1_q, l0_q;
  logic                         z0_q;
  logic [CW-1:0]                ch_q;
  logic [GF_W-1:0]              tbl_in, tbl_res;
  logic                         tbl_err;
  logic [GF_W:0]                diff;
  loc_rsp_t                     res_nxt, rsp_q;

  assign s0_v   = req_s0;
  assign s1_v   = req_s1;
  assign accept = (state == IDLE) && (|req_valid);

  rs_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grant is only visible in IDLE and never while reset is held
  assign req_ready = (rst_n && state == IDLE) ? gnt : '0;

  // Single log table: input steered by state, 0 when unused
  always_comb begin
    tbl_in = '0;
    case (state)
      LOG0:    tbl_in = s0_q;
      LOG1:    tbl_in = s1_q;
      default: tbl_in = '0;
    endcase
  end

  gf_log_3 u_log (
    .op  (tbl_in),
    .res (tbl_res),
    .err (tbl_err)
  );

  // Result formed in LOG1 from registered log S0 and live log S1
  always_comb begin
    diff = (tbl_res >= l0_q) ? ({1'b0, tbl_res} - {1'b0, l0_q})
                             : ({1'b0, tbl_res} + (GF_W+1)'(RS_N) - {1'b0, l0_q});
    res_nxt = '0;
    if (z0_q && tbl_err) begin
      res_nxt.noerr = 1'b1;
    end else if (z0_q ^ tbl_err) begin
      res_nxt.fail = 1'b1;
    end else begin
      res_nxt.pos = GF_W'(diff);
      res_nxt.mag = s0_q;
    end
  end

  // Sequencer: accept, two lookups, one-cycle response strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s0_q      <= '0;
      s1_q      <= '0;
      ch_q      <= '0;
      l0_q      <= '0;
      z0_q      <= 1'b0;
      rsp_q     <= '0;
      rsp_ch    <= '0;
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          s0_q  <= s0_v[gnt_idx];
          s1_q  <= s1_v[gnt_idx];
          ch_q  <= gnt_idx;
          state <= LOG0;
        end
        LOG0: begin
          l0_q  <= tbl_res;
          z0_q  <= tbl_err;
          state <= LOG1;
        end
        LOG1: begin
          rsp_q     <= res_nxt;
          rsp_ch    <= ch_q;
          rsp_valid <= 1'b1;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_pos   = rsp_q.pos;
  assign rsp_mag   = rsp_q.mag;
  assign rsp_noerr = rsp_q.noerr;
  assign rsp_fail  = rsp_q.fail;

endmodule

// File: tb/tb_rs_gf8_locator_sched.sv
// Scoreboard bench for rs_gf8_locator_sched: expected results are queued at
// acceptance and checked by a monitor when rsp_valid pulses.
module tb_rs_gf8_locator_sched;

  localparam int NUM_CH = 4;

  typedef struct packed {
    logic [1:0] ch;
    logic [2:0] pos;
    logic [2:0] mag;
    logic       noerr;
    logic       fail;
  } exp_t;

  logic        clk, rst_n;
  logic [3:0]  req_valid, req_ready;
  logic [11:0] req_s0, req_s1;
  logic        rsp_valid;
  logic [1:0]  rsp_ch;
  logic [2:0]  rsp_pos, rsp_mag;
  logic        rsp_noerr, rsp_fail;

  int   n_cmp = 0, n_bad = 0, cyc = 0, n_rsp = 0, last_rsp_cyc = 0;
  exp_t sb[$];
  int   rsp_cyc_q[$];

  rs_gf8_locator_sched #(.NUM_CH(NUM_CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_s0    (req_s0),
    .req_s1    (req_s1),
    .rsp_valid (rsp_valid),
    .rsp_ch    (rsp_ch),
    .rsp_pos   (rsp_pos),
    .rsp_mag   (rsp_mag),
    .rsp_noerr (rsp_noerr),
    .rsp_fail  (rsp_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter for latency measurements
  always @(posedge clk) cyc <= cyc + 1;

  // Reference log: walk powers of alpha with x^3 + x + 1 reduction
  function automatic int mlog(input logic [2:0] x);
    logic [3:0] p;
    p = 4'd1;
    if (x == 3'd0) return -1;
    for (int i = 0; i < 7; i++) begin
      if (p[2:0] == x) return i;
      p = p << 1;
      if (p[3]) p = p ^ 4'b1011;
    end
    return -2;
  endfunction

  function automatic exp_t model(input int ch, input logic [2:0] a, input logic [2:0] b);
    exp_t e;
    int   la, lb;
    e = '0;
    e.ch = 2'(ch);
    la = mlog(a);
    lb = mlog(b);
    if (la < 0 && lb < 0)      e.noerr = 1'b1;
    else if (la < 0 || lb < 0) e.fail  = 1'b1;
    else begin
      e.pos = 3'((lb - la + 7) % 7);
      e.mag = a;
    end
    return e;
  endfunction

  // Monitor: pop and compare on every response strobe
  always @(negedge clk) begin
    exp_t act, e;
    if (rsp_valid) begin
      act = {rsp_ch, rsp_pos, rsp_mag, rsp_noerr, rsp_fail};
      rsp_cyc_q.push_back(cyc);
      last_rsp_cyc = cyc;
      n_rsp++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL rsp_unexpected got ch=%0d pos=%0d mag=%0d noerr=%b fail=%b want no response",
                 act.ch, act.pos, act.mag, act.noerr, act.fail);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          n_bad++;
          $display("FAIL rsp_fields got ch=%0d pos=%0d mag=%0d noerr=%b fail=%b want ch=%0d pos=%0d mag=%0d noerr=%b fail=%b",
                   act.ch, act.pos, act.mag, act.noerr, act.fail, e.ch, e.pos, e.mag, e.noerr, e.fail);
        end
      end
    end
  end

  // Drive one request, wait for grant, queue its expected result
  task automatic send(input int ch, input logic [2:0] a, input logic [2:0] b, output int acc);
    int n;
    req_s0[3*ch +: 3] = a;
    req_s1[3*ch +: 3] = b;
    req_valid[ch] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[ch] && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    acc = cyc;
    n_cmp++;
    if (!req_ready[ch]) begin
      n_bad++;
      $display("FAIL grant_timeout ch=%0d got ready=%b want grant", ch, req_ready);
      req_valid[ch] = 1'b0;
    end else begin
      sb.push_back(model(ch, a, b));
      @(posedge clk); #1;
      req_valid[ch] = 1'b0;
    end
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (n_rsp < target && n < 20) begin
      @(negedge clk); #2;
      n++;
    end
    n_cmp++;
    if (n_rsp < target) begin
      n_bad++;
      $display("FAIL rsp_timeout got %0d responses want %0d", n_rsp, target);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = 4'b0001;
    req_s0 = 12'h249;
    req_s1 = 12'h5ac;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_ch, rsp_pos, rsp_mag, rsp_noerr, rsp_fail} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got v=%b ch=%0d pos=%0d mag=%0d ne=%b f=%b want all 0",
               rsp_valid, rsp_ch, rsp_pos, rsp_mag, rsp_noerr, rsp_fail);
    end
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_ready got %b want 0000", req_ready);
    end
    req_valid = 4'b0000;
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL idle_ready got %b want 0000", req_ready);
    end
  endtask

  task automatic test_basic;
    int acc, base;
    base = n_rsp;
    send(0, 3'd1, 3'd3, acc);
    wait_rsp(base + 1);
    n_cmp++;
    if (last_rsp_cyc - acc !== 3) begin
      n_bad++;
      $display("FAIL basic_latency got %0d want 3", last_rsp_cyc - acc);
    end
    @(negedge clk); #2;
    n_cmp++;
    if (rsp_valid !== 1'b0 || rsp_pos !== 3'd3 || rsp_mag !== 3'd1) begin
      n_bad++;
      $display("FAIL rsp_hold got v=%b pos=%0d mag=%0d want v=0 pos=3 mag=1", rsp_valid, rsp_pos, rsp_mag);
    end
  endtask

  task automatic test_wrap_busy;
    int acc, base;
    base = n_rsp;
    send(2, 3'd5, 3'd2, acc);
    // ch3 asks while the engine is busy: no grant until IDLE
    req_s0[9 +: 3] = 3'd7;
    req_s1[9 +: 3] = 3'd7;
    req_valid[3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (req_ready !== 4'b0000) begin
        n_bad++;
        $display("FAIL busy_ready step=%0d got %b want 0000", i, req_ready);
      end
      @(posedge clk); #1;
    end
    send(3, 3'd7, 3'd7, acc);
    wait_rsp(base + 2);
  endtask

  task automatic test_flags;
    int acc, base;
    base = n_rsp;
    send(1, 3'd0, 3'd0, acc);
    send(1, 3'd4, 3'd0, acc);
    send(1, 3'd0, 3'd5, acc);
    wait_rsp(base + 3);
    n_cmp++;
    if (rsp_fail !== 1'b1 || rsp_noerr !== 1'b0) begin
      n_bad++;
      $display("FAIL last_flags got fail=%b noerr=%b want fail=1 noerr=0", rsp_fail, rsp_noerr);
    end
  endtask

  task automatic test_round_robin;
    int g, n;
    logic [3:0] exp_r;
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      req_s0[3*c +: 3] = 3'(c + 1);
      req_s1[3*c +: 3] = 3'(c + 2);
    end
    req_valid = 4'b1111;
    @(negedge clk); #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL rr_reset_ready got %b want 0000", req_ready);
    end
    for (int k = 0; k < 8; k++)
      sb.push_back(model(k % 4, 3'((k % 4) + 1), 3'((k % 4) + 2)));
    rsp_cyc_q.delete();
    rst_n = 1'b1;
    #1;
    g = 0;
    n = 0;
    while (g < 8 && n < 60) begin
      if (|req_ready) begin
        exp_r = 4'b0001 << (g % 4);
        n_cmp++;
        if (req_ready !== exp_r) begin
          n_bad++;
          $display("FAIL rr_grant #%0d got %b want %b", g, req_ready, exp_r);
        end
        g++;
      end
      if (g < 8) begin
        @(negedge clk); #1;
        n++;
      end
    end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    n_cmp++;
    if (g != 8) begin
      n_bad++;
      $display("FAIL rr_grant_count got %0d want 8", g);
    end
    n = 0;
    while (rsp_cyc_q.size() < 8 && n < 20) begin
      @(negedge clk); #2;
      n++;
    end
    n_cmp++;
    if (rsp_cyc_q.size() != 8) begin
      n_bad++;
      $display("FAIL rr_rsp_count got %0d want 8", rsp_cyc_q.size());
    end else begin
      for (int i = 1; i < 8; i++) begin
        n_cmp++;
        if (rsp_cyc_q[i] - rsp_cyc_q[i-1] != 4) begin
          n_bad++;
          $display("FAIL rr_spacing #%0d got %0d want 4", i, rsp_cyc_q[i] - rsp_cyc_q[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int acc, base, n;
    base = n_rsp;
    req_s0[9 +: 3] = 3'd6;
    req_s1[9 +: 3] = 3'd7;
    req_valid[3] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[3] && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    @(posedge clk); #1;   // LOG0
    @(posedge clk); #1;   // LOG1
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rsp_valid, rsp_ch, rsp_pos, rsp_mag, rsp_noerr, rsp_fail, req_ready} !== 15'd0) begin
      n_bad++;
      $display("FAIL midreset_outputs got v=%b ch=%0d pos=%0d mag=%0d ne=%b f=%b rdy=%b want all 0",
               rsp_valid, rsp_ch, rsp_pos, rsp_mag, rsp_noerr, rsp_fail, req_ready);
    end
    repeat (3) @(negedge clk);
    #2;
    n_cmp++;
    if (n_rsp != base) begin
      n_bad++;
      $display("FAIL midreset_no_rsp got %0d responses want %0d", n_rsp, base);
    end
    #1;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b1000) begin
      n_bad++;
      $display("FAIL midreset_regrant got %b want 1000", req_ready);
    end
    acc = cyc;
    sb.push_back(model(3, 3'd6, 3'd7));
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    wait_rsp(base + 1);
    n_cmp++;
    if (last_rsp_cyc - acc !== 3) begin
      n_bad++;
      $display("FAIL midreset_latency got %0d want 3", last_rsp_cyc - acc);
    end
  endtask

  task automatic test_sweep;
    int acc, n;
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        send(1, 3'(a), 3'(b), acc);
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk); #2;
      n++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sweep_drain got %0d pending want 0", sb.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_s0 = '0;
    req_s1 = '0;
    test_reset;
    test_basic;
    test_wrap_busy;
    test_flags;
    test_round_robin;
    test_reset_mid;
    test_sweep;
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
